// File: rtl/clk_div_mon_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_mon_pkg
//   Shared definitions for the divided-clock monitor:
//     - mon_state_e : monitor FSM states (IDLE / ACQ / LOCK / FAIL)
//     - DEF_*       : default counter width, lock count and timeout
//     - SYNC_STAGES : depth of the optional clk_mon synchronizer
//     - sat_inc     : saturating increment used by the period/high counters
// -----------------------------------------------------------------------------
package clk_div_mon_pkg;

  localparam int unsigned DEF_CNT_W   = 16;
  localparam int unsigned DEF_LOCK_N  = 4;
  localparam int unsigned DEF_TIMEOUT = 1023;
  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2,
    ST_FAIL = 2'd3
  } mon_state_e;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/clk_div_monitor_edge.sv
// -----------------------------------------------------------------------------
// clk_edge_det
//   Samples the divided clock in the clk_i domain and flags its rising edge.
//   Configuration macro: CLK_DIV_MON_SYNC_EN
//     defined   : clk_mon_i passes a SYNC_STAGES-flop synchronizer before the
//                 sample flop (safe for asynchronous / negedge-generated input;
//                 adds SYNC_STAGES cycles of latency)
//     undefined : clk_mon_i is sampled directly (input must derive from clk_i)
// Ports
//   clk_i      in   source clock, posedge
//   rst_ni     in   asynchronous active-low reset
//   clk_mon_i  in   divided clock under test
//   s_o        out  sampled clk_mon level
//   rise_o     out  one-cycle rising-edge strobe (s & ~s delayed)
// -----------------------------------------------------------------------------
module clk_edge_det
  import clk_div_mon_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clk_mon_i,
  output logic s_o,
  output logic rise_o
);

  logic samp_in;
  logic s_q;
  logic s_dly_q;

`ifdef CLK_DIV_MON_SYNC_EN
  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_mon_i};
    end
  end

  assign samp_in = sync_q[SYNC_STAGES-1];
`else
  assign samp_in = clk_mon_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_q     <= 1'b0;
      s_dly_q <= 1'b0;
    end else begin
      s_q     <= samp_in;
      s_dly_q <= s_q;
    end
  end

  assign s_o    = s_q;
  assign rise_o = s_q & ~s_dly_q;

endmodule

// File: rtl/clk_div_monitor.sv
// -----------------------------------------------------------------------------
// clk_div_monitor
//   Checker for the odd/even clock divider. Measures the period and high time
//   of clk_mon in clk_in cycles, compares each period against the window
//   [per_min, per_max] and reports lock / sticky error status.
//   Configuration macro: CLK_DIV_MON_SYNC_EN (handled inside clk_edge_det);
//   when defined all detection latencies grow by two cycles.
// Parameters
//   CNT_W    counter / window width
//   LOCK_N   consecutive in-window periods needed for lock (1..255)
//   TIMEOUT  clk_in cycles without a clk_mon rise that count as a fault
// Ports
//   clk_in    in   source clock, posedge
//   rst_n     in   asynchronous active-low reset
//   en        in   monitor enable; low returns to IDLE on the next edge
//   clk_mon   in   divided clock under test
//   per_min   in   minimum legal period (inclusive)
//   per_max   in   maximum legal period (inclusive)
//   err_clr   in   one-cycle pulse: clear err, FAIL -> ACQ
//   period    out  last measured rise-to-rise period
//   high_cnt  out  sampled-high cycles within the last period
//   meas_vld  out  one-cycle pulse when period/high_cnt update
//   locked    out  high while in LOCK
//   err       out  sticky fault flag
// -----------------------------------------------------------------------------
module clk_div_monitor
  import clk_div_mon_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned LOCK_N  = DEF_LOCK_N,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clk_mon,
  input  logic [CNT_W-1:0] per_min,
  input  logic [CNT_W-1:0] per_max,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_cnt,
  output logic             meas_vld,
  output logic             locked,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TMO_C   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [7:0]       LOCK_C  = 8'(LOCK_N);

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [7:0]       gcnt_q, gcnt_d;
  logic             first_q, first_d;
  logic             err_q, err_d;
  logic             meas_vld_q, meas_vld_d;

  logic s;
  logic rise;
  logic meas;
  logic good;
  logic timeout;
  logic fault;

  function automatic logic [CNT_W-1:0] inc_cnt(input logic [CNT_W-1:0] v);
    logic [31:0] w;
    w = sat_inc(32'(v), 32'(CNT_MAX));
    return w[CNT_W-1:0];
  endfunction

  clk_edge_det u_edge (
    .clk_i     (clk_in),
    .rst_ni    (rst_n),
    .clk_mon_i (clk_mon),
    .s_o       (s),
    .rise_o    (rise)
  );

  // In the rise cycle cnt_q still holds the length of the period just ended.
  assign good = (cnt_q >= per_min) && (cnt_q <= per_max);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hcnt_d     = hcnt_q;
    period_d   = period_q;
    high_d     = high_q;
    gcnt_d     = gcnt_q;
    first_d    = first_q;
    err_d      = err_q;
    meas_vld_d = 1'b0;
    meas       = 1'b0;
    timeout    = 1'b0;
    fault      = 1'b0;

    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      hcnt_d  = '0;
      gcnt_d  = '0;
      err_d   = 1'b0;
      first_d = 1'b0;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_ACQ;
      cnt_d   = '0;
      hcnt_d  = '0;
      gcnt_d  = '0;
      first_d = 1'b1;
    end else begin
      // Measurement keeps running in FAIL so period/high_cnt stay live for
      // debug; only ACQ and LOCK act on the results.
      if (rise) begin
        cnt_d   = CNT_ONE;
        hcnt_d  = CNT_ONE;
        first_d = 1'b0;
        if (!first_q) begin
          meas       = 1'b1;
          meas_vld_d = 1'b1;
          period_d   = cnt_q;
          high_d     = hcnt_q;
        end
      end else begin
        cnt_d = inc_cnt(cnt_q);
        if (s) begin
          hcnt_d = inc_cnt(hcnt_q);
        end
        // Exact compare: a saturated counter never matches again, so one
        // gap produces one timeout.
        timeout = (cnt_q == TMO_C);
      end

      fault = (meas && !good) || timeout;

      // Clear first so that a coincident fault wins.
      if (err_clr) begin
        err_d = 1'b0;
      end

      case (state_q)
        ST_ACQ: begin
          if (fault) begin
            err_d  = 1'b1;
            gcnt_d = '0;
          end else if (meas) begin
            gcnt_d = gcnt_q + 8'd1;
            if (gcnt_q + 8'd1 >= LOCK_C) begin
              state_d = ST_LOCK;
            end
          end
        end
        ST_LOCK: begin
          if (fault) begin
            state_d = ST_FAIL;
            err_d   = 1'b1;
          end
        end
        ST_FAIL: begin
          if (err_clr) begin
            state_d = ST_ACQ;
            gcnt_d  = '0;
            first_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      hcnt_q     <= '0;
      period_q   <= '0;
      high_q     <= '0;
      gcnt_q     <= '0;
      first_q    <= 1'b0;
      err_q      <= 1'b0;
      meas_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hcnt_q     <= hcnt_d;
      period_q   <= period_d;
      high_q     <= high_d;
      gcnt_q     <= gcnt_d;
      first_q    <= first_d;
      err_q      <= err_d;
      meas_vld_q <= meas_vld_d;
    end
  end

  assign period   = period_q;
  assign high_cnt = high_q;
  assign meas_vld = meas_vld_q;
  assign locked   = (state_q == ST_LOCK);
  assign err      = err_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
module tb_clk_div_monitor;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned TMO   = 16;
`ifdef CLK_DIV_MON_SYNC_EN
  localparam int unsigned LAT = 3;
`else
  localparam int unsigned LAT = 1;
`endif

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic             en;
  logic             clk_mon;
  logic [CNT_W-1:0] per_min;
  logic [CNT_W-1:0] per_max;
  logic             err_clr;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_cnt;
  logic             meas_vld;
  logic             locked;
  logic             err;

  typedef struct {
    int unsigned per;
    int unsigned hi;
    int unsigned cyc;
    bit          lk;
    bit          er;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned last_rise = 0;
  int unsigned prev_len = 0;
  int unsigned prev_hi  = 0;

  clk_div_monitor #(
    .CNT_W   (CNT_W),
    .LOCK_N  (4),
    .TIMEOUT (TMO)
  ) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .en       (en),
    .clk_mon  (clk_mon),
    .per_min  (per_min),
    .per_max  (per_max),
    .err_clr  (err_clr),
    .period   (period),
    .high_cnt (high_cnt),
    .meas_vld (meas_vld),
    .locked   (locked),
    .err      (err)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // One clock: drive inputs, sample 1 time unit after the edge, score meas_vld.
  task automatic step(input logic v, input logic clr);
    exp_t e;
    bit   exp_vld;
    clk_mon = v;
    err_clr = clr;
    @(posedge clk_in);
    #1;
    cyc++;
    err_clr = 1'b0;
    exp_vld = (sb.size() > 0) && (sb[0].cyc == cyc);
    check("meas_vld", 32'(meas_vld), 32'(exp_vld));
    if (exp_vld) begin
      e = sb.pop_front();
      check("period",   32'(period),   e.per);
      check("high_cnt", 32'(high_cnt), e.hi);
      check("locked",   32'(locked),   32'(e.lk));
      check("err",      32'(err),      32'(e.er));
    end
  endtask

  // One clk_mon period: hi samples high then zeros. The rise at its start
  // closes the previous period; when meas is set that measurement is queued
  // with the lock/err state expected right after it.
  task automatic drive_period(input int unsigned len, input int unsigned hi, input bit meas,
                              input bit lk, input bit er, input int clr_idx);
    exp_t e;
    if (meas) begin
      e.per = prev_len; e.hi = prev_hi; e.cyc = cyc + 1 + LAT; e.lk = lk; e.er = er;
      sb.push_back(e);
    end
    last_rise = cyc + 1;
    for (int i = 0; i < int'(len); i++) begin
      step(i < int'(hi), i == clr_idx);
    end
    prev_len = len;
    prev_hi  = hi;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_period"}, 32'(period),   0);
    check({tag, "_high"},   32'(high_cnt), 0);
    check({tag, "_vld"},    32'(meas_vld), 0);
    check({tag, "_locked"}, 32'(locked),   0);
    check({tag, "_err"},    32'(err),      0);
  endtask

  initial begin
    bit exp_e;
    rst_n   = 1'b0;
    en      = 1'b0;
    clk_mon = 1'b0;
    err_clr = 1'b0;
    per_min = 16'd3;
    per_max = 16'd3;
    #2;
    check_idle_outputs("reset");
    repeat (3) @(posedge clk_in);
    #1;
    rst_n = 1'b1;
    en    = 1'b1;
    step(0, 0);
    step(0, 0);

    // Lock: 1,0,0 repeating; locks on the 4th measurement.
    drive_period(3, 1, 0, 0, 0, -1);
    repeat (3) drive_period(3, 1, 1, 0, 0, -1);
    drive_period(3, 1, 1, 1, 0, -1);
    drive_period(3, 1, 1, 1, 0, -1);

    // Bad period of 4 -> FAIL; err_clr once FAIL is reached, then relock.
    drive_period(4, 1, 1, 1, 0, -1);
    drive_period(6, 1, 1, 0, 1, int'(LAT) + 1);
    check("fail_locked", 32'(locked), 0);
    check("fail_cleared_err", 32'(err), 0);
    drive_period(3, 1, 0, 0, 0, -1);
    repeat (3) drive_period(3, 1, 1, 0, 0, -1);
    drive_period(3, 1, 1, 1, 0, -1);

    // Timeout: clk_mon held low after lock.
    for (int i = 0; i < 30; i++) begin
      step(0, 0);
      exp_e = (cyc >= last_rise + TMO + LAT);
      check("tmo_err", 32'(err), 32'(exp_e));
      check("tmo_locked", 32'(locked), 32'(!exp_e));
    end

    // err_clr alone from FAIL, then inverted window and coincident fault/clear.
    step(0, 1);
    check("clr_err", 32'(err), 0);
    per_min = 16'd5;
    per_max = 16'd2;
    drive_period(5, 1, 0, 0, 0, -1);
    drive_period(5, 1, 1, 0, 1, -1);
    drive_period(5, 2, 1, 0, 1, int'(LAT));

    // Back to 3/3: one bad (the 5-period), then four good -> lock, err sticky.
    per_min = 16'd3;
    per_max = 16'd3;
    drive_period(3, 1, 1, 0, 1, -1);
    repeat (3) drive_period(3, 1, 1, 0, 1, -1);
    drive_period(3, 1, 1, 1, 1, -1);
    drive_period(3, 1, 1, 1, 1, -1);
    repeat (4) step(0, 0);
    check("pre_en_locked", 32'(locked), 1);

    // en=0 while locked: locked/err drop next edge, period/high_cnt hold.
    en = 1'b0;
    step(0, 0);
    check("en0_locked", 32'(locked), 0);
    check("en0_err", 32'(err), 0);
    check("en0_period", 32'(period), 3);
    check("en0_high", 32'(high_cnt), 1);
    step(0, 0);
    en = 1'b1;
    step(0, 0);

    // Reacquire, then async reset in the middle of a cycle.
    drive_period(3, 1, 0, 0, 0, -1);
    drive_period(2, 1, 1, 0, 0, -1);
    drive_period(3, 1, 1, 0, 1, -1);
    repeat (4) step(0, 0);
    check("pre_rst_period", 32'(period), 2);
    #3;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    #2;
    rst_n = 1'b1;
    step(0, 0);
    step(1, 0);
    check_idle_outputs("post_rst");

    check("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
